tgate_phase_gen: RTL and testbench
==================================

TGATE_PHASE_GEN -- requirements
Module: tgate_phase_gen

Interface
REQ-001 The module SHALL have parameter ON, default 2, giving the cycles each phase is conducting (ON >= 1).
REQ-002 The module SHALL have parameter DEAD, default 1, giving the all-off cycles after each phase (DEAD >= 1).
REQ-003 The module SHALL have parameter CNTW, default 8, giving the shift-count width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  request a burst of nshift two-phase shifts; sampled only in IDLE.
REQ-007 nshift  input  CNTW  number of shifts in the burst; sampled with start.
REQ-008 abort  input  1  synchronous burst cancel.
REQ-009 n1, p1  output  1 each  phase-1 transmission-gate controls (nmos gate, pmos gate).
REQ-010 n2, p2  output  1 each  phase-2 transmission-gate controls.
REQ-011 busy  output  1  burst in progress.
REQ-012 done  output  1  one-cycle pulse at normal burst completion.
REQ-013 shift_count  output  CNTW  completed shifts in current/last burst.

Function
REQ-014 All outputs SHALL be registered; FSM states SHALL be IDLE, PH1, DEAD1, PH2, DEAD2.
REQ-015 p1 SHALL equal NOT n1 and p2 SHALL equal NOT n2 in every cycle.
REQ-016 n1 and n2 SHALL never be 1 in the same cycle; n1=1 only in PH1, n2=1 only in PH2.
REQ-017 IDLE with start=1 and nshift!=0 at edge E0: load remaining=nshift, clear shift_count, enter PH1; busy=1 and n1=1 from E0.
REQ-018 IDLE with start=1 and nshift=0: no phase activity, busy stays 0, done=1 for one cycle from E0.
REQ-019 PH1 SHALL last exactly ON cycles then DEAD1; DEAD1 exactly DEAD cycles then PH2; PH2 exactly ON cycles then DEAD2; DEAD2 exactly DEAD cycles.
REQ-020 At end of DEAD2: shift_count increments by 1 and remaining decrements by 1; if remaining becomes 0 go IDLE, else go PH1.
REQ-021 One shift SHALL take 2*(ON+DEAD) cycles; burst completion edge = E0 + nshift*2*(ON+DEAD).
REQ-022 At completion edge busy=0, done=1 for exactly one cycle, shift_count=nshift held until next accepted start.
REQ-023 start while busy SHALL be ignored (no reload, no restart).
REQ-024 abort=1 in any non-IDLE state: next edge all phases off (n1=n2=0, p1=p2=1), busy=0, IDLE, no done pulse, shift_count retains completed shifts.
REQ-025 abort and start same cycle in IDLE: abort wins, start ignored.
REQ-026 nshift = 2^CNTW-1 SHALL run to completion without counter wrap; shift_count SHALL not overflow.
REQ-027 Internal phase timer width SHALL hold max(ON,DEAD)-1; ON<1 or DEAD<1 SHALL be rejected at elaboration.

Reset
REQ-028 rst=1 at an edge: state IDLE, n1=n2=0, p1=p2=1, busy=0, done=0, shift_count=0, remaining=0.
REQ-029 rst mid-burst SHALL behave as REQ-028 at that edge with no done pulse; rst dominates abort and start.
REQ-030 After rst deasserts, first start SHALL be accepted at the first edge it is sampled high.

Verification
REQ-031 Defaults, start=1 nshift=3 at E0 -> n1=1 edges E0..E0+1, all off E0+2, n2=1 E0+3..E0+4, off E0+5; done=1 only at E0+18; shift_count=3.
REQ-032 start with nshift=0 -> done one cycle, busy never 1, n1/n2 never 1.
REQ-033 nshift=5, abort at E0+8 -> outputs off and busy=0 at E0+8, done never asserted, shift_count=1.
REQ-034 nshift=2, start pulsed again at E0+4 with nshift=7 -> ignored; done at E0+12, shift_count=2.
REQ-035 rst asserted at E0+3 of nshift=4 burst -> all REQ-028 values at E0+3; new start next cycle runs full burst.
REQ-036 Random ON/DEAD/nshift/abort run with assertions: p1==~n1, p2==~n2, !(n1&n2), phase lengths exact, done only on normal completion.

Source files
------------

// File: rtl/tgate_phase_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : tgate_phase_gen_if
//  Brief    : Control and status bundle for the two-phase transmission-gate
//             generator: burst request inputs and gate-drive / status outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface tgate_phase_gen_if #(
   parameter int CNTW = 8
);
   logic            start;
   logic [CNTW-1:0] nshift;
   logic            abort;
   logic            n1;
   logic            p1;
   logic            n2;
   logic            p2;
   logic            busy;
   logic            done;
   logic [CNTW-1:0] shift_count;

   // Requester side: issues bursts, observes gate drives and status
   modport master (
      output start, nshift, abort,
      input  n1, p1, n2, p2, busy, done, shift_count
   );

   // Generator side
   modport slave (
      input  start, nshift, abort,
      output n1, p1, n2, p2, busy, done, shift_count
   );
endinterface
`default_nettype wire

// File: rtl/tgate_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tgate_phase_gen
//  Brief    : Non-overlapping two-phase transmission-gate driver. Each shift is
//             PH1 (ON cycles), DEAD1 (DEAD cycles), PH2 (ON), DEAD2 (DEAD).
//             A burst of nshift shifts is launched by start; abort and rst
//             cancel without a done pulse. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module tgate_phase_gen #(
   parameter int ON   = 2,
   parameter int DEAD = 1,
   parameter int CNTW = 8
) (
   input  logic             clk,
   input  logic             rst,
   tgate_phase_gen_if.slave bus
);

   // Timer only ever needs to reach max(ON,DEAD)-1
   localparam int MAXLEN = (ON > DEAD) ? ON : DEAD;
   localparam int TW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

   localparam logic [TW-1:0] ON_LAST   = TW'(ON - 1);
   localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PH1   = 3'd1;
   localparam logic [2:0] S_DEAD1 = 3'd2;
   localparam logic [2:0] S_PH2   = 3'd3;
   localparam logic [2:0] S_DEAD2 = 3'd4;

   generate
      if (ON < 1 || DEAD < 1) begin : g_param_check
         $error("tgate_phase_gen: ON and DEAD must both be at least 1");
      end
   endgenerate

   logic [2:0]      state,     state_nxt;
   logic [TW-1:0]   timer,     timer_nxt;
   logic [CNTW-1:0] remaining, remaining_nxt;
   logic [CNTW-1:0] count,     count_nxt;
   logic            done_nxt;

   // Next-state: phase sequencing, burst bookkeeping, abort override
   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      remaining_nxt = remaining;
      count_nxt     = count;
      done_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            // abort in IDLE suppresses a simultaneous start
            if (bus.start && !bus.abort) begin
               count_nxt = '0;
               if (bus.nshift != '0) begin
                  state_nxt     = S_PH1;
                  timer_nxt     = '0;
                  remaining_nxt = bus.nshift;
               end else begin
                  // empty burst completes immediately
                  done_nxt = 1'b1;
               end
            end
         end
         S_PH1: begin
            if (timer == ON_LAST) begin
               state_nxt = S_DEAD1;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_DEAD1: begin
            if (timer == DEAD_LAST) begin
               state_nxt = S_PH2;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_PH2: begin
            if (timer == ON_LAST) begin
               state_nxt = S_DEAD2;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_DEAD2: begin
            if (timer == DEAD_LAST) begin
               timer_nxt     = '0;
               count_nxt     = count + 1'b1;
               remaining_nxt = remaining - 1'b1;
               if (remaining == CNTW'(1)) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_PH1;
               end
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
         end
      endcase

      // Cancel keeps the shifts already completed, never pulses done
      if (bus.abort && (state != S_IDLE)) begin
         state_nxt     = S_IDLE;
         timer_nxt     = '0;
         remaining_nxt = '0;
         count_nxt     = count;
         done_nxt      = 1'b0;
      end
   end

   // State and registered outputs; gate drives decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         timer     <= '0;
         remaining <= '0;
         count     <= '0;
         bus.n1    <= 1'b0;
         bus.p1    <= 1'b1;
         bus.n2    <= 1'b0;
         bus.p2    <= 1'b1;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         remaining <= remaining_nxt;
         count     <= count_nxt;
         bus.n1    <= (state_nxt == S_PH1);
         bus.p1    <= (state_nxt != S_PH1);
         bus.n2    <= (state_nxt == S_PH2);
         bus.p2    <= (state_nxt != S_PH2);
         bus.busy  <= (state_nxt != S_IDLE);
         bus.done  <= done_nxt;
      end
   end

   assign bus.shift_count = count;

endmodule
`default_nettype wire

// File: tb/tb_tgate_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tgate_phase_gen
//  Brief    : Scoreboard bench for tgate_phase_gen. A cycle-offset model of
//             the burst waveform pushes expected outputs each edge; a monitor
//             pops and compares on the opposite edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tgate_phase_gen;

   localparam int ON   = 2;
   localparam int DEAD = 1;
   localparam int CNTW = 8;
   localparam int P    = 2 * (ON + DEAD);

   typedef struct packed {
      logic            n1;
      logic            p1;
      logic            n2;
      logic            p2;
      logic            busy;
      logic            done;
      logic [CNTW-1:0] cnt;
   } exp_t;

   logic clk;
   logic rst;

   tgate_phase_gen_if #(.CNTW(CNTW)) bus ();

   tgate_phase_gen #(
      .ON   (ON),
      .DEAD (DEAD),
      .CNTW (CNTW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   exp_t want;
   exp_t got;
   exp_t e;
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: burst active, edges since acceptance, length
   bit   m_busy = 1'b0;
   bit   m_done = 1'b0;
   int   m_k    = 0;
   int   m_n    = 0;
   int   m_cnt  = 0;
   int   r;

   // Reference model: waveform as a function of offset into the burst
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_cnt  = 0;
      end else if (m_busy) begin
         m_done = 1'b0;
         if (bus.abort) begin
            m_busy = 1'b0;
         end else begin
            m_k++;
            if (m_k == m_n * P) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_cnt  = m_n;
            end else begin
               m_cnt = m_k / P;
            end
         end
      end else begin
         m_done = 1'b0;
         if (bus.start && !bus.abort) begin
            m_cnt = 0;
            if (bus.nshift == '0) begin
               m_done = 1'b1;
            end else begin
               m_busy = 1'b1;
               m_k    = 0;
               m_n    = int'(bus.nshift);
            end
         end
      end
      e.n1 = 1'b0;
      e.n2 = 1'b0;
      if (m_busy) begin
         r    = m_k % P;
         e.n1 = (r < ON);
         e.n2 = (r >= ON + DEAD) && (r < 2 * ON + DEAD);
      end
      e.p1   = ~e.n1;
      e.p2   = ~e.n2;
      e.busy = m_busy;
      e.done = m_done;
      e.cnt  = CNTW'(m_cnt);
      exp_q.push_back(e);
   end

   // Monitor: compare DUT outputs against the oldest expectation
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         got  = '{n1: bus.n1, p1: bus.p1, n2: bus.n2, p2: bus.p2,
                  busy: bus.busy, done: bus.done, cnt: bus.shift_count};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL cycle t=%0t n1p1n2p2 busy done cnt: got %b%b%b%b %b %b %0d, expected %b%b%b%b %b %b %0d",
                     $time, got.n1, got.p1, got.n2, got.p2, got.busy, got.done, got.cnt,
                     want.n1, want.p1, want.n2, want.p2, want.busy, want.done, want.cnt);
         end
      end
   end

   task automatic pulse_start(input int n);
      bus.start  = 1'b1;
      bus.nshift = CNTW'(n);
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.nshift = '0;
      bus.abort  = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(2);

      // Three-shift burst with default timing
      pulse_start(3);
      idle(24);

      // Empty burst
      pulse_start(0);
      idle(4);

      // Abort at E0+8 of a five-shift burst
      pulse_start(5);
      idle(7);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      idle(4);

      // Restart attempt while busy is ignored
      pulse_start(2);
      idle(3);
      pulse_start(7);
      idle(14);

      // Reset at E0+3, then immediate new burst
      pulse_start(4);
      idle(2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulse_start(4);
      idle(28);

      // Abort and start together in IDLE: abort wins
      bus.abort = 1'b1;
      pulse_start(3);
      bus.abort = 1'b0;
      idle(4);

      // Maximum burst length, no counter wrap
      pulse_start((1 << CNTW) - 1);
      idle(((1 << CNTW) - 1) * P + 4);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.start  = ($urandom_range(0, 7) == 0);
         bus.nshift = CNTW'($urandom_range(0, 6));
         bus.abort  = ($urandom_range(0, 59) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst       = 1'b0;
      idle(50);

      // Every model expectation must have been consumed by the monitor
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
